muldiv_issue_ctrl: RTL
======================

Name: muldiv_issue_ctrl

Overview:
- Initiator side of the multiply/divide core interface.
- Accepts mult/div requests from the control unit and parks the core (holds `md_reset`) while idle.
- Launches one operation per request, waits for `md_done`, and captures HI/LO into architectural registers.
- Reports busy and divide-by-zero status to the pipeline control.

Parameters:
- WIDTH, 32, operand/result width.
- TIMEOUT_CYCLES, 48, WAIT-state cycle limit (used only with the optional feature).
- CNT_W, 7, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  operation request.
- req_op  in  1  0 = multiply, 1 = divide.
- req_a  in  WIDTH  operand A (dividend/multiplicand).
- req_b  in  WIDTH  operand B (divisor/multiplier).
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready.
- busy  out  1  high in ARM/WAIT; pipeline stalls on mfhi/mflo/new mult-div while set.
- rd_sel  in  1  0 = HI, 1 = LO.
- rd_data  out  WIDTH  combinational mux of hi_q/lo_q.
- hi_q  out  WIDTH  architectural HI.
- lo_q  out  WIDTH  architectural LO.
- resp_valid  out  1  one-cycle pulse: operation finished.
- div0  out  1  one-cycle pulse with resp_valid: divisor was zero.
- timeout  out  1  one-cycle pulse: watchdog abort (0 without feature).
- md_op  out  1  to core: operation select.
- md_a  out  WIDTH  to core: operand A.
- md_b  out  WIDTH  to core: operand B.
- md_reset  out  1  to core: restart/park.
- md_hi  in  WIDTH  from core: HI result.
- md_lo  in  WIDTH  from core: LO result.
- md_done  in  1  from core: done flag (may be sticky).
- md_divby0  in  1  from core: divide-by-zero flag.

Behaviour:
- Reset values:
  - state = IDLE.
  - hi_q = lo_q = 0.
  - op/a/b latches = 0.
  - resp_valid = div0 = timeout = 0.
  - md_reset = 1.
  - req_ready = 1, busy = 0.
- md_op/md_a/md_b are driven from internal latches only. They are never combinational from req_*, and are stable from acceptance until return to IDLE.
- IDLE:
  - md_reset = 1, parking the core and clearing any stale done.
  - On req_valid: latch req_op/a/b, go to ARM.
- ARM (exactly 1 cycle):
  - md_reset = 0; the core performs its initialise step.
  - md_done is ignored this cycle. A done from the previous op may still be visible; it is suppressed.
  - Go to WAIT.
- WAIT:
  - md_reset = 0.
  - First cycle with md_done = 1: go to IDLE.
    - If md_op = 1 and md_divby0 = 1: hi_q/lo_q unchanged; next cycle resp_valid = 1 and div0 = 1.
    - Otherwise: hi_q <= md_hi, lo_q <= md_lo; next cycle resp_valid = 1, div0 = 0.
- Latency: resp_valid rises 1 cycle after md_done is first sampled high in WAIT. Controller overhead is 2 cycles beyond the core's compute time.
- Back-to-back: resp_valid is asserted while in IDLE, so a request presented that same cycle is accepted. No bubble beyond the pulse.
- Request while busy: req_ready = 0. The requester holds its values; nothing is latched.
- rd_data while busy returns the previous HI/LO. Hazard stalling is upstream's job, using busy.
- Reset mid-operation: immediate return to IDLE on the next edge, with all reset values. md_reset = 1 aborts the core and no resp_valid is issued.
- md_done outside WAIT is ignored.

Optional Feature:
- Macro name: MULDIV_TIMEOUT_EN.
- With the macro defined:
  - A CNT_W counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with md_done still 0: go to IDLE, hi_q/lo_q unchanged, timeout pulses 1 cycle, no resp_valid.
  - md_done in the same cycle as the limit wins: normal capture, no timeout.
- Without the macro: no counter, timeout tied to 0, WAIT lasts indefinitely.

Decomposition:
- Shared package muldiv_pkg holds:
  - state enum {IDLE, ARM, WAIT};
  - op constants MD_OP_MULT = 1'b0, MD_OP_DIV = 1'b1;
  - WIDTH default;
  - DIV0 sentinel 32'h7FFFFFFF, for bench checks.
- Optional sub-module muldiv_watchdog (counter plus limit compare), instantiated only under MULDIV_TIMEOUT_EN.
- Everything else lives in one module.

Test Plan:
- mult 7 × −3 (req_b = 0xFFFFFFFD) against the mult/div core -> single resp_valid pulse; hi_q = 0xFFFFFFFF, lo_q = 0xFFFFFFEB; div0 = 0.
- div −7 / 3 (req_a = 0xFFFFFFF9) -> lo_q = 0xFFFFFFFE, hi_q = 0xFFFFFFFF.
- Preload HI/LO via mult 2 × 3 (lo_q = 6, hi_q = 0), then div 5 / 0 -> resp_valid with div0 = 1; hi_q = 0, lo_q = 6 unchanged.
- Back-to-back requests: mult 3 × 4, then div 100 / 7 presented in the resp_valid cycle -> second accepted immediately; sticky done from the first not captured during ARM; final lo_q = 14, hi_q = 2.
- Assert reset 10 cycles into a WAIT -> next cycle: state IDLE, md_reset = 1, hi_q = lo_q = 0; no resp_valid ever issued for the aborted op.
- With MULDIV_TIMEOUT_EN, stub core holding md_done = 0 -> timeout pulse exactly TIMEOUT_CYCLES (48) cycles after WAIT entry; HI/LO unchanged; req_ready = 1 next cycle.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide issue controller.
// Consumers: muldiv_issue_ctrl, muldiv_watchdog (only when MULDIV_TIMEOUT_EN is defined).

package muldiv_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    localparam logic MD_OP_MULT = 1'b0;
    localparam logic MD_OP_DIV  = 1'b1;

    // Value a divider core typically leaves on HI/LO after a zero divisor.
    localparam logic [31:0] DIV0 = 32'h7FFFFFFF;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        WAIT
    } state_e;

endpackage

// File: rtl/muldiv_watchdog.sv
// WAIT-state cycle counter for the multiply/divide issue controller.
// Instantiated only when MULDIV_TIMEOUT_EN is defined.

module muldiv_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 48,
    parameter int unsigned CNT_W          = 7
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Fires on the last allowed WAIT cycle, so the abort edge lands exactly TIMEOUT_CYCLES in.
    assign expired = enable && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// Initiator side of the multiply/divide core interface: latches a request, runs the core,
// captures HI/LO. Optional WAIT watchdog is enabled by defining MULDIV_TIMEOUT_EN.

module muldiv_issue_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH          = DEFAULT_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 48,
    parameter int unsigned CNT_W          = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             req_ready,
    output logic             busy,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q,
    output logic             resp_valid,
    output logic             div0,
    output logic             timeout,
    output logic             md_op,
    output logic [WIDTH-1:0] md_a,
    output logic [WIDTH-1:0] md_b,
    output logic             md_reset,
    input  logic [WIDTH-1:0] md_hi,
    input  logic [WIDTH-1:0] md_lo,
    input  logic             md_done,
    input  logic             md_divby0
);

    if ((1 << CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_cnt_w
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    state_e           state_q, state_d;
    logic             op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             accept;
    logic             capture;
    logic             resp_valid_d;
    logic             div0_d;

    assign accept    = (state_q == IDLE) && req_valid;
    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    // Holding the core in reset while idle also clears any sticky done from the last op.
    assign md_reset  = (state_q == IDLE);
    assign md_op     = op_q;
    assign md_a      = a_q;
    assign md_b      = b_q;
    assign rd_data   = rd_sel ? lo_q : hi_q;

`ifdef MULDIV_TIMEOUT_EN
    logic wd_expired;
    logic timeout_d;
    logic timeout_q;

    muldiv_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (state_q == ARM),
        .enable  (state_q == WAIT),
        .expired (wd_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        capture      = 1'b0;
        resp_valid_d = 1'b0;
        div0_d       = 1'b0;
`ifdef MULDIV_TIMEOUT_EN
        timeout_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = ARM;
                end
            end
            // A stale done may still be visible here; it is deliberately ignored.
            ARM: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (md_done) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b1;
                    if ((op_q == MD_OP_DIV) && md_divby0) begin
                        div0_d = 1'b1;
                    end else begin
                        capture = 1'b1;
                    end
                end
`ifdef MULDIV_TIMEOUT_EN
                else if (wd_expired) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= MD_OP_MULT;
            a_q        <= '0;
            b_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            resp_valid <= 1'b0;
            div0       <= 1'b0;
        end else begin
            state_q    <= state_d;
            resp_valid <= resp_valid_d;
            div0       <= div0_d;
            if (accept) begin
                op_q <= req_op;
                a_q  <= req_a;
                b_q  <= req_b;
            end
            if (capture) begin
                hi_q <= md_hi;
                lo_q <= md_lo;
            end
        end
    end

endmodule
